snake_motion_engine: RTL and testbench
======================================

Name: snake_motion_engine

Overview:
- Game-state stage sitting directly upstream of the VGA controller.
- Owns snake 1's head position, 10-slot body list, length, score and game stage on the 40x40 board (positions 0..1599 = 40*row+col).
- Advances one cell per move tick from the up/down/left/right buttons; detects apple, wall and self collisions.
- Top level packs outputs into the snake_data bus: head→[231:200], length→[295:264], stage→[359:328], body→[629:520].

Parameters:
- MOVE_DIV, 2500000, clock cycles per move tick (≈10 moves/s at 25 MHz).
- START_POS, 820, head cell on (re)start (row 20, col 20).
- INIT_LEN, 3, body segments on (re)start (1..MAX_LEN).
- MAX_LEN, 10, body slots; fixed to match the 110-bit body bus.
- EMPTY, 2047, sentinel for unused body slots; never a board cell.

Ports:
- iVGA_CLK  in  1  system clock.
- iRST_n  in  1  asynchronous active-low reset.
- iStart  in  1  level; starts or restarts a game.
- up  in  1  direction button, active high.
- down  in  1  direction button, active high.
- left  in  1  direction button, active high.
- right  in  1  direction button, active high.
- iApplePos  in  11  current apple cell.
- oHead  out  11  head cell.
- oBody  out  110  slot i at [11i+10:11i]; slot 0 is adjacent to the head.
- oLength  out  4  active body slots.
- oStage  out  2  0=IDLE, 2=PLAY, 3=OVER; zero-extended to 32 bits by the top.
- oScore  out  20  apples eaten, binary.
- oAppleEaten  out  1  one-cycle pulse.

Behaviour:
- Reset: all outputs clear immediately on iRST_n low, independent of the clock.
  - oStage=0, oHead=START_POS, all body slots=EMPTY.
  - oLength=0, oScore=0, oAppleEaten=0, direction=RIGHT, tick counter=0.
- Game init happens on IDLE or OVER with iStart=1, sampled at the clock edge. It sets:
  - oStage=2, head=START_POS, slot k=START_POS-(k+1) for k<INIT_LEN, other slots=EMPTY.
  - oLength=INIT_LEN, oScore=0, dir=RIGHT, pending=RIGHT, counter=0.
- iStart is ignored in PLAY.
- Tick counter:
  - Runs only in PLAY and counts 0..MOVE_DIV-1.
  - The tick is the cycle where the counter equals MOVE_DIV-1; the counter then wraps to 0.
- Direction input:
  - Buttons are sampled every cycle in PLAY.
  - If several are pressed, priority is up>down>left>right.
  - A request opposite to the committed dir is ignored; otherwise it overwrites pending.
  - pending is committed to dir at each tick, so the new direction takes effect on that tick.
- On tick, next = head-40 (up), +40 (down), -1 (left), +1 (right).
- Wall collision:
  - Triggers for up at row 0, down at row 39, left at col 0, right at col 39.
  - Result: stage→3; head, body, length and score are frozen.
- Eat: next==iApplePos.
- Self collision:
  - next equals an active slot i<oLength.
  - The tail slot (oLength-1) is excluded when not eating, because the tail vacates that cell.
  - Result: stage→3, state frozen.
  - Wall collision takes precedence over self collision, which takes precedence over eat.
- Normal move:
  - slot i←slot i-1 for i≥1, slot 0←head, head←next.
  - If not eating, slot oLength←EMPTY, so the length is unchanged.
- Eating:
  - The shift keeps the old tail slot, and oLength increments, saturating at MAX_LEN. At MAX_LEN no growth occurs.
  - oScore increments, saturating at 999999.
  - oAppleEaten pulses for one cycle; all registered updates land the cycle after the tick.
- Latency: button press to head change ≤ MOVE_DIV+1 cycles.
- Invariants:
  - Slots ≥ oLength always hold EMPTY.
  - oHead and active slots are always <1600.

Optional Feature:
- Macro: SNAKE_WRAP_EN.
- Defined: wall collision is disabled. Exiting a row wraps to the same row at the opposite column (col 39→0 and 0→39). Exiting a column wraps row 39→0 and 0→39 (next = head±1560). Self collision is still fatal.
- Undefined: wall collision → OVER as specified above.

Test Plan:
- Reset mid-PLAY with MOVE_DIV=4: assert iRST_n=0 asynchronously → outputs immediately show oStage=0, oHead=820, all slots 2047, oLength=0.
- iStart pulse, MOVE_DIV=4, no buttons, apple=0 → oStage=2, body 819/818/817. After the first tick: oHead=821, slot0=820, slot2=818, slot3=2047.
- During a move right, press left → ignored. Press up then tick → oHead=821-40=781.
- Apple at 822, head 821, moving right → next cycle: oAppleEaten=1 for one cycle, oLength=4, slot3=818, oScore=1.
- Head at 839 (col 39) moving right, macro undefined → oStage=3, oHead stays 839. With SNAKE_WRAP_EN: oHead=800, oStage=2.
- Length 4, U-turn sequence up, left, down into body slot 2 → oStage=3. A move into the vacating tail cell without eating → stays PLAY. In OVER, iStart=1 → re-init values as in the second scenario.

Source files
------------

// File: rtl/snake_motion_engine.sv
// Snake 1 game-state engine: head, 10-slot body, length, score and stage on a 40x40 board.
// Build option: define SNAKE_WRAP_EN to wrap the snake around the board edges instead of ending the game.
module snake_motion_engine #(
    parameter int MOVE_DIV  = 2500000,
    parameter int START_POS = 820,
    parameter int INIT_LEN  = 3,
    parameter int MAX_LEN   = 10,
    parameter int EMPTY     = 2047
) (
    input  logic         iVGA_CLK,
    input  logic         iRST_n,
    input  logic         iStart,
    input  logic         up,
    input  logic         down,
    input  logic         left,
    input  logic         right,
    input  logic [10:0]  iApplePos,
    output logic [10:0]  oHead,
    output logic [109:0] oBody,
    output logic [3:0]   oLength,
    output logic [1:0]   oStage,
    output logic [19:0]  oScore,
    output logic         oAppleEaten,
    output logic [629:0] snake_data
);

    localparam int              CNT_W     = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVE_DIV - 1);
    localparam logic [10:0]     START_W   = 11'(START_POS);
    localparam logic [10:0]     EMPTY_W   = 11'(EMPTY);
    localparam logic [3:0]      INIT_W    = 4'(INIT_LEN);
    localparam logic [3:0]      MAX_W     = 4'(MAX_LEN);
    localparam logic [19:0]     SCORE_MAX = 20'd999999;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd2,
        ST_OVER = 2'd3
    } stage_t;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    stage_t           stage, stage_n;
    dir_t             dir, dir_n, pending, pending_n, pending_eff, req;
    logic [10:0]      head, head_n, next_pos;
    logic [10:0]      body [MAX_LEN];
    logic [10:0]      body_n [MAX_LEN];
    logic [3:0]       length, length_n;
    logic [19:0]      score, score_n;
    logic             eaten, eaten_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [5:0]       col;
    logic             req_valid, edge_hit, wall, eat, self_hit;

    function automatic dir_t opposite(input dir_t d);
        case (d)
            DIR_UP:   return DIR_DOWN;
            DIR_DOWN: return DIR_UP;
            DIR_LEFT: return DIR_RIGHT;
            default:  return DIR_LEFT;
        endcase
    endfunction

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            stage   <= ST_IDLE;
            head    <= START_W;
            for (int i = 0; i < MAX_LEN; i++) body[i] <= EMPTY_W;
            length  <= 4'd0;
            score   <= 20'd0;
            eaten   <= 1'b0;
            dir     <= DIR_RIGHT;
            pending <= DIR_RIGHT;
            cnt     <= '0;
        end else begin
            stage   <= stage_n;
            head    <= head_n;
            for (int i = 0; i < MAX_LEN; i++) body[i] <= body_n[i];
            length  <= length_n;
            score   <= score_n;
            eaten   <= eaten_n;
            dir     <= dir_n;
            pending <= pending_n;
            cnt     <= cnt_n;
        end
    end

    // Direction request and candidate cell; the edge case also yields the wrapped cell.
    always_comb begin
        req_valid = 1'b1;
        req       = DIR_RIGHT;
        if (up)         req = DIR_UP;
        else if (down)  req = DIR_DOWN;
        else if (left)  req = DIR_LEFT;
        else if (right) req = DIR_RIGHT;
        else            req_valid = 1'b0;
        pending_eff = (req_valid && req != opposite(dir)) ? req : pending;

        col      = 6'(head % 11'd40);
        edge_hit = 1'b0;
        next_pos = head;
        case (pending_eff)
            DIR_UP: begin
                edge_hit = (head < 11'd40);
                next_pos = edge_hit ? head + 11'd1560 : head - 11'd40;
            end
            DIR_DOWN: begin
                edge_hit = (head >= 11'd1560);
                next_pos = edge_hit ? head - 11'd1560 : head + 11'd40;
            end
            DIR_LEFT: begin
                edge_hit = (col == 6'd0);
                next_pos = edge_hit ? head + 11'd39 : head - 11'd1;
            end
            default: begin
                edge_hit = (col == 6'd39);
                next_pos = edge_hit ? head - 11'd39 : head + 11'd1;
            end
        endcase
`ifdef SNAKE_WRAP_EN
        wall = 1'b0;
`else
        wall = edge_hit;
`endif

        eat      = (next_pos == iApplePos);
        self_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (4'(i) < length && body[i] == next_pos && (eat || 4'(i) != length - 4'd1))
                self_hit = 1'b1;
        end
    end

    // Stage machine and all registered game-state updates.
    always_comb begin
        stage_n   = stage;
        head_n    = head;
        for (int i = 0; i < MAX_LEN; i++) body_n[i] = body[i];
        length_n  = length;
        score_n   = score;
        eaten_n   = 1'b0;
        dir_n     = dir;
        pending_n = pending;
        cnt_n     = cnt;

        case (stage)
            ST_IDLE, ST_OVER: begin
                if (iStart) begin
                    stage_n   = ST_PLAY;
                    head_n    = START_W;
                    for (int i = 0; i < MAX_LEN; i++)
                        body_n[i] = (i < INIT_LEN) ? START_W - 11'(i + 1) : EMPTY_W;
                    length_n  = INIT_W;
                    score_n   = 20'd0;
                    dir_n     = DIR_RIGHT;
                    pending_n = DIR_RIGHT;
                    cnt_n     = '0;
                end
            end
            ST_PLAY: begin
                pending_n = pending_eff;
                cnt_n     = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
                if (cnt == CNT_LAST) begin
                    dir_n = pending_eff;
                    if (wall || self_hit) begin
                        stage_n = ST_OVER;
                    end else begin
                        body_n[0] = head;
                        for (int i = 1; i < MAX_LEN; i++) body_n[i] = body[i-1];
                        head_n = next_pos;
                        if (eat) begin
                            eaten_n = 1'b1;
                            if (length < MAX_W)      length_n = length + 4'd1;
                            if (score < SCORE_MAX)   score_n  = score + 20'd1;
                        end else begin
                            for (int i = 0; i < MAX_LEN; i++)
                                if (4'(i) == length) body_n[i] = EMPTY_W;
                        end
                    end
                end
            end
            default: stage_n = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) oBody[11*i +: 11] = body[i];
    end

    assign oHead       = head;
    assign oLength     = length;
    assign oStage      = stage;
    assign oScore      = score;
    assign oAppleEaten = eaten;

    always_comb begin
        snake_data          = '0;
        snake_data[231:200] = {21'd0, head};
        snake_data[295:264] = {28'd0, length};
        snake_data[359:328] = {30'd0, stage};
        snake_data[629:520] = oBody;
    end

endmodule

// File: tb/tb_snake_motion_engine.sv
// Scoreboard bench for snake_motion_engine with MOVE_DIV=4; honours SNAKE_WRAP_EN for the edge scenario.
module tb_snake_motion_engine;

    localparam logic [10:0] EMPTY_W = 11'd2047;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         up, down, left, right;
    logic [10:0]  apple;
    logic [10:0]  head;
    logic [109:0] body;
    logic [3:0]   length;
    logic [1:0]   stage;
    logic [19:0]  score;
    logic         eaten;
    logic [629:0] snake_data;

    typedef struct packed {
        logic [10:0]  head;
        logic [109:0] body;
        logic [3:0]   len;
        logic [1:0]   stage;
        logic [19:0]  score;
        logic         eaten;
    } snap_t;

    typedef struct {
        int    at;
        snap_t snap;
    } exp_t;

    exp_t  exp_q [$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    base;
    snap_t cur, prev;
    bit    first = 1'b1;

    snake_motion_engine #(.MOVE_DIV(4)) dut (
        .iVGA_CLK(clk), .iRST_n(rst_n), .iStart(start),
        .up(up), .down(down), .left(left), .right(right),
        .iApplePos(apple),
        .oHead(head), .oBody(body), .oLength(length), .oStage(stage),
        .oScore(score), .oAppleEaten(eaten), .snake_data(snake_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic u, input logic d, input logic l, input logic r);
        up = u; down = d; left = l; right = r;
    endtask

    task automatic expectState(input int at, input logic [10:0] h, input logic [3:0] len,
                               input logic [1:0] st, input logic [19:0] sc, input logic ea,
                               input logic [10:0] s0, input logic [10:0] s1,
                               input logic [10:0] s2, input logic [10:0] s3);
        exp_t e;
        e.at         = at;
        e.snap.head  = h;
        e.snap.body  = {{6{EMPTY_W}}, s3, s2, s1, s0};
        e.snap.len   = len;
        e.snap.stage = st;
        e.snap.score = sc;
        e.snap.eaten = ea;
        exp_q.push_back(e);
    endtask

    task automatic expectReset();
        exp_t e;
        e.at         = -1;
        e.snap.head  = 11'd820;
        e.snap.body  = {10{EMPTY_W}};
        e.snap.len   = 4'd0;
        e.snap.stage = 2'd0;
        e.snap.score = 20'd0;
        e.snap.eaten = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e, input snap_t got, input int at);
        checks++;
        if (got !== e.snap || (e.at >= 0 && e.at != at)) begin
            errors++;
            $display("[TB] FAIL state got head=%0d body=%h len=%0d stage=%0d score=%0d eaten=%0b cyc=%0d, required head=%0d body=%h len=%0d stage=%0d score=%0d eaten=%0b cyc=%0d",
                     got.head, got.body, got.len, got.stage, got.score, got.eaten, at,
                     e.snap.head, e.snap.body, e.snap.len, e.snap.stage, e.snap.score, e.snap.eaten, e.at);
        end
    endtask

    task automatic checkValue(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got %0h required %0h", name, got, want);
        end
    endtask

    // Monitor: every observed change of the visible state must match the next scoreboard entry.
    initial begin
        forever begin
            @(negedge clk);
            cur = {head, body, length, stage, score, eaten};
            if (first || cur !== prev) begin
                first = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_change head=%0d len=%0d stage=%0d cyc=%0d", head, length, stage, cyc);
                end else begin
                    checkOutput(exp_q.pop_front(), cur, cyc);
                end
                prev = cur;
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        apple = 11'd0;
        applyStimulus(0, 0, 0, 0);
        expectReset();
        #1 rst_n = 1'b0;
        waitCycles(3);
        rst_n = 1'b1;
        waitCycles(1);

        $display("[TB] first game: move, eat, turn, self collision");
        start = 1'b1;
        base  = cyc + 1;
        expectState(base, 820, 3, 2, 0, 0, 819, 818, 817, EMPTY_W);
        waitCycles(1);
        start = 1'b0;
        expectState(base + 4, 821, 3, 2, 0, 0, 820, 819, 818, EMPTY_W);
        waitCycles(4);
        applyStimulus(0, 0, 1, 0);
        apple = 11'd822;
        expectState(base + 8, 822, 4, 2, 1, 1, 821, 820, 819, 818);
        expectState(base + 9, 822, 4, 2, 1, 0, 821, 820, 819, 818);
        waitCycles(4);
        apple = 11'd0;
        applyStimulus(1, 0, 0, 0);
        waitCycles(1);
        applyStimulus(0, 0, 0, 0);
        expectState(base + 12, 782, 4, 2, 1, 0, 822, 821, 820, 819);
        waitCycles(3);
        applyStimulus(0, 0, 1, 0);
        expectState(base + 16, 781, 4, 2, 1, 0, 782, 822, 821, 820);
        waitCycles(1);
        applyStimulus(0, 0, 0, 0);
        waitCycles(3);
        applyStimulus(0, 1, 0, 0);
        expectState(base + 20, 781, 4, 3, 1, 0, 782, 822, 821, 820);
        waitCycles(1);
        applyStimulus(0, 0, 0, 0);
        waitCycles(6);

        $display("[TB] restart from OVER, start held into PLAY, move into vacating tail");
        start = 1'b1;
        base  = cyc + 1;
        expectState(base, 820, 3, 2, 0, 0, 819, 818, 817, EMPTY_W);
        applyStimulus(1, 0, 0, 0);
        waitCycles(3);
        start = 1'b0;
        applyStimulus(0, 0, 0, 0);
        expectState(base + 4, 780, 3, 2, 0, 0, 820, 819, 818, EMPTY_W);
        waitCycles(2);
        applyStimulus(0, 0, 1, 0);
        expectState(base + 8, 779, 3, 2, 0, 0, 780, 820, 819, EMPTY_W);
        waitCycles(1);
        applyStimulus(0, 0, 0, 0);
        waitCycles(3);
        applyStimulus(0, 1, 0, 0);
        expectState(base + 12, 819, 3, 2, 0, 0, 779, 780, 820, EMPTY_W);
        waitCycles(1);
        applyStimulus(0, 0, 0, 0);
        waitCycles(5);

        $display("[TB] asynchronous reset in PLAY");
        expectReset();
        #1 rst_n = 1'b0;
        #1;
        checkValue("async_stage", 128'(stage), 128'd0);
        checkValue("async_head", 128'(head), 128'd820);
        checkValue("async_body", 128'(body), 128'({10{EMPTY_W}}));
        checkValue("async_length", 128'(length), 128'd0);
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(1);

        $display("[TB] run right to the board edge");
        start = 1'b1;
        base  = cyc + 1;
        expectState(base, 820, 3, 2, 0, 0, 819, 818, 817, EMPTY_W);
        waitCycles(1);
        start = 1'b0;
        for (int k = 1; k <= 19; k++)
            expectState(base + 4 * k, 11'(820 + k), 3, 2, 0, 0,
                        11'(819 + k), 11'(818 + k), 11'(817 + k), EMPTY_W);
`ifdef SNAKE_WRAP_EN
        expectState(base + 80, 800, 3, 2, 0, 0, 839, 838, 837, EMPTY_W);
`else
        expectState(base + 80, 839, 3, 3, 0, 0, 838, 837, 836, EMPTY_W);
`endif
        waitCycles(82);

`ifdef SNAKE_WRAP_EN
        checkValue("bus_head", 128'(snake_data[231:200]), 128'd800);
        checkValue("bus_stage", 128'(snake_data[359:328]), 128'd2);
        checkValue("bus_body", 128'(snake_data[629:520]), 128'({{7{EMPTY_W}}, 11'd837, 11'd838, 11'd839}));
`else
        checkValue("bus_head", 128'(snake_data[231:200]), 128'd839);
        checkValue("bus_stage", 128'(snake_data[359:328]), 128'd3);
        checkValue("bus_body", 128'(snake_data[629:520]), 128'({{7{EMPTY_W}}, 11'd836, 11'd837, 11'd838}));
`endif
        checkValue("bus_length", 128'(snake_data[295:264]), 128'd3);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL pending_expectations got %0d entries left required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
